inst_fetch_queue: RTL
=====================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 Parameter XLEN, default 32, address and instruction width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 pc  in  32  fetch address from the PC stage.
REQ-007 inst_ce  in  1  PC stage requests a fetch of pc.
REQ-008 pc_ready  out  1  pulse: pc accepted; PC stage may advance.
REQ-009 imem_req  out  1  instruction memory request valid.
REQ-010 imem_addr  out  32  request address, always {pc[31:2],2'b00}.
REQ-011 imem_gnt  in  1  memory accepts request this cycle.
REQ-012 imem_rvalid  in  1  response data valid.
REQ-013 imem_rdata  in  32  response instruction word.
REQ-014 flush  in  1  discard queue and in-flight fetch (branch/jump redirect).
REQ-015 id_valid  out  1  queue head valid to decode.
REQ-016 id_ready  in  1  decode consumes head this cycle.
REQ-017 id_inst  out  32  head instruction.
REQ-018 id_pc  out  32  address of head instruction.

Function
REQ-019 FSM states IDLE, WAIT_GNT, WAIT_RESP, DROP; at most one outstanding request.
REQ-020 IDLE: inst_ce=1 and count<DEPTH and flush=0 -> latch pc, go WAIT_GNT; otherwise stay.
REQ-021 WAIT_GNT: imem_req=1, imem_addr from latched pc; imem_gnt=1 -> pc_ready=1 that cycle, go WAIT_RESP.
REQ-022 imem_req SHALL stay asserted with a stable address until grant or flush.
REQ-023 WAIT_RESP: imem_rvalid=1 -> push {latched pc, imem_rdata}, go IDLE; rvalid in IDLE or WAIT_GNT is ignored.
REQ-024 The slot for an outstanding fetch SHALL be reserved, so a push never finds the queue full.
REQ-025 Push is visible as id_valid the cycle after rvalid; minimum grant-to-id_valid latency is 2 cycles.
REQ-026 Pop occurs when id_valid & id_ready; push and pop in the same cycle leave count unchanged.
REQ-027 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-028 Full (count==DEPTH) blocks new requests; empty (count==0) forces id_valid=0.
REQ-029 id_inst and id_pc SHALL be stable while id_valid=1 and id_ready=0.
REQ-030 Flush SHALL take priority: clear count/pointers and ignore same-cycle push/pop; no pc_ready is issued.
REQ-031 Flush in WAIT_GNT -> drop imem_req next cycle, go IDLE; flush with same-cycle imem_gnt -> DROP.
REQ-032 Flush in WAIT_RESP -> DROP, or IDLE if imem_rvalid is also high that cycle (data discarded).
REQ-033 DROP: discard the next rvalid, then go IDLE; no new request is issued while in DROP.

Reset
REQ-034 Reset values: state IDLE, count 0, pointers 0, id_valid 0, imem_req 0, pc_ready 0, id_inst 0, id_pc 0, imem_addr 0.
REQ-035 Reset mid-operation SHALL abandon any outstanding fetch; a later rvalid is ignored in IDLE.

Structure
REQ-036 Shared package holds the FSM state encoding, XLEN and the default DEPTH.
REQ-037 Queue storage and pointer logic SHALL live in one sub-module, fetch_fifo; the FSM stays in inst_fetch_queue.

Verification
REQ-038 Reset then inst_ce=1, pc=0x0, gnt same cycle, rvalid 1 cycle later with 0x20080005 -> id_valid with id_pc=0x0 and id_inst=0x20080005, 2 cycles after grant.
REQ-039 id_ready=0; fetch pc 0x0,0x4,0x8,0xC -> count=4, imem_req stays 0 despite inst_ce; one pop -> request for 0x10 issued.
REQ-040 gnt delayed 3 cycles -> imem_req/imem_addr stable, a single pc_ready pulse on the grant cycle.
REQ-041 flush during WAIT_RESP for 0x8 with 2 queued -> id_valid=0 next cycle; next rvalid dropped; next fetch pushes only the new pc.
REQ-042 Sustained push+pop at count=1 across pointer wrap (12 fetches, id_ready=1) -> in-order id_pc 0x0..0x2C, no loss or duplication.
REQ-043 rst asserted in WAIT_RESP, rvalid arrives next cycle -> queue stays empty, all outputs at reset values.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
`default_nettype none
//==============================================================================
// Package  : inst_fetch_queue_pkg
// Brief    : Shared widths, default depth and fetch FSM encoding.
// Revision : 1.0 - initial release
//==============================================================================
package inst_fetch_queue_pkg;

    localparam int c_xlen          = 32;
    localparam int c_depth_default = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_GNT  = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DROP      = 2'd3
    } fetch_state_e;

endpackage : inst_fetch_queue_pkg
`default_nettype wire

// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
//==============================================================================
// Interface: inst_fetch_queue_if
// Brief    : PC-stage, instruction-memory and decode handshakes of the queue.
// Revision : 1.0 - initial release
//==============================================================================
interface inst_fetch_queue_if
    import inst_fetch_queue_pkg::*;
#(
    parameter int XLEN = c_xlen
);

    logic [XLEN-1:0] pc;
    logic            inst_ce;
    logic            pc_ready;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;

    // The fetch queue itself
    modport master (
        input  pc, inst_ce, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
        output pc_ready, imem_req, imem_addr, id_valid, id_inst, id_pc
    );

    // PC stage, memory and decode seen from the outside
    modport slave (
        output pc, inst_ce, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
        input  pc_ready, imem_req, imem_addr, id_valid, id_inst, id_pc
    );

endinterface : inst_fetch_queue_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
//==============================================================================
// Module   : fetch_fifo
// Brief    : Circular {pc, instruction} queue with flush; head read is direct.
// Revision : 1.0 - initial release
//==============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             flush,
    input  wire             push,
    input  wire [XLEN-1:0]  push_pc,
    input  wire [XLEN-1:0]  push_inst,
    input  wire             ready,
    output logic            valid,
    output logic            full,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_inst
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [XLEN-1:0]    r_mem_pc   [DEPTH];
    logic [XLEN-1:0]    r_mem_inst [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_pop;

    assign valid     = (r_count != '0);
    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign w_pop     = valid & ready;
    assign head_pc   = r_mem_pc[r_rd_ptr];
    assign head_inst = r_mem_inst[r_rd_ptr];

    // Storage is cleared on reset so the head outputs read zero afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]   <= '0;
                r_mem_inst[i] <= '0;
            end
        end else if (push && !flush) begin
            r_mem_pc[r_wr_ptr]   <= push_pc;
            r_mem_inst[r_wr_ptr] <= push_inst;
        end
    end

    // Flush wins over any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
//==============================================================================
// Module   : inst_fetch_queue
// Brief    : Single-outstanding instruction fetcher feeding a decode queue.
// Revision : 1.0 - initial release
//==============================================================================
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = c_depth_default,
    parameter int XLEN  = c_xlen
) (
    input  wire                 clk,
    input  wire                 rst,
    inst_fetch_queue_if.master  bus
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic            w_latch_pc;
    logic            w_push;
    logic            w_req;
    logic            w_pc_ready;
    logic            w_full;
    logic            w_id_valid;
    logic [XLEN-1:0] w_id_pc;
    logic [XLEN-1:0] w_id_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch_pc) begin
                r_pc <= bus.pc;
            end
        end
    end

    // Only IDLE may start a fetch, so checking full there keeps a slot free
    // for the single outstanding response.
    always_comb begin
        w_state_nxt = r_state;
        w_latch_pc  = 1'b0;
        w_push      = 1'b0;
        w_req       = 1'b0;
        w_pc_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.inst_ce && !w_full && !bus.flush) begin
                    w_latch_pc  = 1'b1;
                    w_state_nxt = ST_WAIT_GNT;
                end
            end
            ST_WAIT_GNT: begin
                w_req = 1'b1;
                if (bus.flush) begin
                    w_state_nxt = bus.imem_gnt ? ST_DROP : ST_IDLE;
                end else if (bus.imem_gnt) begin
                    w_pc_ready  = 1'b1;
                    w_state_nxt = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (bus.flush) begin
                    w_state_nxt = bus.imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (bus.imem_rvalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (bus.imem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .push      (w_push),
        .push_pc   (r_pc),
        .push_inst (bus.imem_rdata),
        .ready     (bus.id_ready),
        .valid     (w_id_valid),
        .full      (w_full),
        .head_pc   (w_id_pc),
        .head_inst (w_id_inst)
    );

    assign bus.pc_ready  = w_pc_ready;
    assign bus.imem_req  = w_req;
    assign bus.imem_addr = {r_pc[XLEN-1:2], 2'b00};
    assign bus.id_valid  = w_id_valid;
    assign bus.id_pc     = w_id_pc;
    assign bus.id_inst   = w_id_inst;

endmodule : inst_fetch_queue
`default_nettype wire
